// File: rtl/reply_encoder.sv
`default_nettype none
// ============================================================================
// Module      : reply_encoder
// Description : Collects response bytes written by on-board sources and
//               frames each burst as
//                   PREFIX, SELF_ADDR, SRC, LEN, DATA[0..LEN-1], CRC
//               on a valid/ready byte stream toward the UART transmitter.
//               CRC is the modulo-256 sum of the DATA bytes only.
//
// Ports       : clk           system clock
//               n_rst         asynchronous active-low reset
//               in_data       byte from a source
//               in_valid_bus  one-hot write strobe, bit i = source i
//               in_ready      encoder can accept a byte this cycle
//               tx_data       framed byte to UART
//               tx_valid      tx_data valid
//               tx_ready      UART accepts tx_data
//               busy          encoder not idle
//               drop          one-cycle pulse: offered byte discarded or
//                             frame aborted
//
// Options     : TX_TIMEOUT_EN  when defined, a stalled transmitter
//                              (tx_valid & !tx_ready for TX_TIMEOUT_CYC
//                              cycles) aborts the frame.
//
// Revision    : 1.0  initial release
// ============================================================================
module reply_encoder #(
    parameter int          N_SRC          = 8,
    parameter logic [7:0]  PREFIX         = 8'hA5,
    parameter logic [7:0]  SELF_ADDR      = 8'h3C,
    parameter int          MAX_LEN        = 64,
    parameter int          GAP_CYC        = 16,
    parameter int          TX_TIMEOUT_CYC = 50000000
) (
    input  logic             clk,
    input  logic             n_rst,
    input  logic [7:0]       in_data,
    input  logic [N_SRC-1:0] in_valid_bus,
    output logic             in_ready,
    output logic [7:0]       tx_data,
    output logic             tx_valid,
    input  logic             tx_ready,
    output logic             busy,
    output logic             drop
);

    localparam int               c_SRC_W    = (N_SRC > 1) ? $clog2(N_SRC) : 1;
    localparam int               c_AW       = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
    localparam int               c_GAP_W    = $clog2(GAP_CYC + 1);
    localparam logic [7:0]       c_MAX_LEN  = 8'(MAX_LEN);
    localparam logic [c_GAP_W-1:0] c_GAP_LAST = c_GAP_W'(GAP_CYC - 1);

    typedef enum logic [3:0] {
        S_IDLE        = 4'd0,
        S_COLLECT     = 4'd1,
        S_SEND_PREFIX = 4'd2,
        S_SEND_ADDR   = 4'd3,
        S_SEND_SRC    = 4'd4,
        S_SEND_LEN    = 4'd5,
        S_SEND_DATA   = 4'd6,
        S_SEND_CRC    = 4'd7
    } state_t;

    state_t               r_state;
    logic [7:0]           r_cnt;
    logic [7:0]           r_crc;
    logic [7:0]           r_rd;
    logic [c_SRC_W-1:0]   r_src;
    logic [c_GAP_W-1:0]   r_gap;
    logic [7:0]           r_mem [0:MAX_LEN-1];

    logic                 w_offer;
    logic                 w_multi;
    logic [c_SRC_W-1:0]   w_win;
    logic                 w_room;
    logic                 w_tx_fire;
    logic                 w_timeout;
    logic                 w_wr_en;
    logic [c_AW-1:0]      w_wr_idx;
    logic [7:0]           w_rd_next;

    assign w_offer   = |in_valid_bus;
    // More than one strobe set: clearing the lowest set bit leaves something.
    assign w_multi   = |(in_valid_bus & (in_valid_bus - N_SRC'(1)));
    assign w_room    = (r_cnt < c_MAX_LEN);
    assign w_tx_fire = tx_valid & tx_ready;
    assign w_rd_next = r_rd + 8'd1;

    assign in_ready  = (r_state == S_IDLE) | ((r_state == S_COLLECT) & w_room);
    assign busy      = (r_state != S_IDLE);

    // Lowest set strobe wins; scan from the top so the lowest index is last.
    always_comb begin
        w_win = '0;
        for (int i = N_SRC - 1; i >= 0; i--) begin
            if (in_valid_bus[i]) begin
                w_win = c_SRC_W'(i);
            end
        end
    end

    // A byte lands in the buffer when it starts a frame or extends the
    // current source's frame while there is room.
    always_comb begin
        w_wr_en  = 1'b0;
        w_wr_idx = '0;
        if (r_state == S_IDLE) begin
            w_wr_en  = w_offer;
        end else if (r_state == S_COLLECT) begin
            w_wr_en  = w_offer & w_room & (w_win == r_src);
            w_wr_idx = r_cnt[c_AW-1:0];
        end
    end

    always_ff @(posedge clk) begin
        if (w_wr_en) begin
            r_mem[w_wr_idx] <= in_data;
        end
    end

`ifdef TX_TIMEOUT_EN
    logic [31:0] r_stall;

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_stall <= '0;
        end else if ((r_state == S_IDLE) || (r_state == S_COLLECT) ||
                     !tx_valid || tx_ready || w_timeout) begin
            r_stall <= '0;
        end else begin
            r_stall <= r_stall + 32'd1;
        end
    end

    assign w_timeout = tx_valid & ~tx_ready & (r_stall == 32'(TX_TIMEOUT_CYC - 1));
`else
    // Watchdog not built: the stall limit has no effect.
    assign w_timeout = 1'b0 & (TX_TIMEOUT_CYC != 0);
`endif

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_state  <= S_IDLE;
            tx_valid <= 1'b0;
            tx_data  <= 8'd0;
            drop     <= 1'b0;
            r_cnt    <= 8'd0;
            r_crc    <= 8'd0;
            r_src    <= '0;
            r_rd     <= 8'd0;
            r_gap    <= '0;
        end else begin
            // Any offer the encoder cannot take is discarded and flagged.
            drop <= w_offer & ~in_ready;

            if (w_timeout) begin
                tx_valid <= 1'b0;
                drop     <= 1'b1;
                r_cnt    <= 8'd0;
                r_crc    <= 8'd0;
                r_state  <= S_IDLE;
            end else begin
                case (r_state)
                    S_IDLE: begin
                        if (w_offer) begin
                            r_src   <= w_win;
                            r_cnt   <= 8'd1;
                            r_crc   <= in_data;
                            r_gap   <= '0;
                            drop    <= w_multi;
                            r_state <= S_COLLECT;
                        end
                    end

                    S_COLLECT: begin
                        if (!w_room) begin
                            // Buffer full: close the frame without a gap wait.
                            tx_data  <= PREFIX;
                            tx_valid <= 1'b1;
                            r_state  <= S_SEND_PREFIX;
                        end else if (w_offer) begin
                            if (w_win == r_src) begin
                                r_cnt <= r_cnt + 8'd1;
                                r_crc <= r_crc + in_data;
                                r_gap <= '0;
                                drop  <= w_multi;
                            end else begin
                                // Another source interrupts: its byte is lost
                                // and the current burst is closed.
                                drop     <= 1'b1;
                                tx_data  <= PREFIX;
                                tx_valid <= 1'b1;
                                r_state  <= S_SEND_PREFIX;
                            end
                        end else if (r_gap == c_GAP_LAST) begin
                            tx_data  <= PREFIX;
                            tx_valid <= 1'b1;
                            r_state  <= S_SEND_PREFIX;
                        end else begin
                            r_gap <= r_gap + c_GAP_W'(1);
                        end
                    end

                    S_SEND_PREFIX: begin
                        if (w_tx_fire) begin
                            tx_data <= SELF_ADDR;
                            r_state <= S_SEND_ADDR;
                        end
                    end

                    S_SEND_ADDR: begin
                        if (w_tx_fire) begin
                            tx_data <= 8'(r_src);
                            r_state <= S_SEND_SRC;
                        end
                    end

                    S_SEND_SRC: begin
                        if (w_tx_fire) begin
                            tx_data <= r_cnt;
                            r_state <= S_SEND_LEN;
                        end
                    end

                    S_SEND_LEN: begin
                        if (w_tx_fire) begin
                            tx_data <= r_mem[0];
                            r_rd    <= 8'd0;
                            r_state <= S_SEND_DATA;
                        end
                    end

                    S_SEND_DATA: begin
                        if (w_tx_fire) begin
                            if (r_rd == r_cnt - 8'd1) begin
                                tx_data <= r_crc;
                                r_state <= S_SEND_CRC;
                            end else begin
                                r_rd    <= w_rd_next;
                                tx_data <= r_mem[w_rd_next[c_AW-1:0]];
                            end
                        end
                    end

                    S_SEND_CRC: begin
                        if (w_tx_fire) begin
                            tx_valid <= 1'b0;
                            r_cnt    <= 8'd0;
                            r_crc    <= 8'd0;
                            r_state  <= S_IDLE;
                        end
                    end

                    default: begin
                        tx_valid <= 1'b0;
                        r_state  <= S_IDLE;
                    end
                endcase
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_reply_encoder.sv
`default_nettype none
// ============================================================================
// Module      : tb_reply_encoder
// Description : Directed self-checking bench for reply_encoder. Frames are
//               captured from the tx stream and compared byte by byte with
//               hand-computed expectations.
// Revision    : 1.0  initial release
// ============================================================================
module tb_reply_encoder;

    localparam int         N_SRC     = 8;
    localparam logic [7:0] PREFIX    = 8'hA5;
    localparam logic [7:0] SELF_ADDR = 8'h3C;
    localparam int         MAX_LEN   = 64;
    localparam int         GAP_CYC   = 16;
    localparam int         TO_CYC    = 20;

    logic             clk = 1'b0;
    logic             n_rst = 1'b0;
    logic [7:0]       in_data = 8'd0;
    logic [N_SRC-1:0] in_valid_bus = '0;
    logic             in_ready;
    logic [7:0]       tx_data;
    logic             tx_valid;
    logic             tx_ready = 1'b1;
    logic             busy;
    logic             drop;

    int               n_checks = 0;
    int               n_pass   = 0;
    logic [7:0]       rx_q[$];

    reply_encoder #(
        .N_SRC          (N_SRC),
        .PREFIX         (PREFIX),
        .SELF_ADDR      (SELF_ADDR),
        .MAX_LEN        (MAX_LEN),
        .GAP_CYC        (GAP_CYC),
        .TX_TIMEOUT_CYC (TO_CYC)
    ) dut (
        .clk          (clk),
        .n_rst        (n_rst),
        .in_data      (in_data),
        .in_valid_bus (in_valid_bus),
        .in_ready     (in_ready),
        .tx_data      (tx_data),
        .tx_valid     (tx_valid),
        .tx_ready     (tx_ready),
        .busy         (busy),
        .drop         (drop)
    );

    always #5 clk = ~clk;

    // Capture every byte that will transfer on the coming rising edge.
    always @(negedge clk) begin
        if (n_rst && tx_valid && tx_ready) begin
            rx_q.push_back(tx_data);
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_bytes(input int src, input logic [7:0] bytes[$]);
        foreach (bytes[i]) begin
            in_valid_bus = N_SRC'(1) << src;
            in_data      = bytes[i];
            tick();
        end
        in_valid_bus = '0;
    endtask

    task automatic check_frame(input string tag, input int src,
                               input logic [7:0] data[$], input logic [7:0] crc);
        logic [7:0] exp[$];
        int         cyc;
        exp.push_back(PREFIX);
        exp.push_back(SELF_ADDR);
        exp.push_back(8'(src));
        exp.push_back(8'(data.size()));
        foreach (data[i]) exp.push_back(data[i]);
        exp.push_back(crc);
        cyc = 0;
        while ((rx_q.size() < exp.size() || busy) && cyc < 400) begin
            tick();
            cyc++;
        end
        check({tag, "_done"}, 32'(cyc < 400), 32'd1);
        check({tag, "_len"}, rx_q.size(), exp.size());
        for (int i = 0; i < exp.size() && i < rx_q.size(); i++) begin
            check($sformatf("%s_b%0d", tag, i), rx_q[i], exp[i]);
        end
        rx_q.delete();
    endtask

    initial begin
        logic [7:0] d[$];
        int         cyc;
        int         stable;

        // Reset state
        #12;
        check("rst_tx_valid", tx_valid, 0);
        check("rst_tx_data",  tx_data,  0);
        check("rst_drop",     drop,     0);
        check("rst_busy",     busy,     0);
        check("rst_in_ready", in_ready, 1);
        n_rst = 1'b1;
        tick();

        // 1: three bytes from source 2, frame closes after GAP_CYC idle cycles
        d = '{8'h01, 8'h02, 8'h03};
        send_bytes(2, d);
        for (int i = 0; i < GAP_CYC - 1; i++) tick();
        check("t1_gap_hold", tx_valid, 0);
        tick();
        check("t1_gap_close_valid", tx_valid, 1);
        check("t1_gap_close_data",  tx_data,  PREFIX);
        check_frame("t1", 2, d, 8'h06);
        check("t1_busy_end", busy, 0);

        // 2: CRC wraps modulo 256
        d = '{8'hFF, 8'h02};
        send_bytes(0, d);
        check_frame("t2", 0, d, 8'h01);

        // 3: full buffer closes the frame at once; extra offer is dropped
        d.delete();
        for (int i = 0; i < MAX_LEN; i++) d.push_back(8'(i));
        send_bytes(1, d);
        check("t3_in_ready_full", in_ready, 0);
        in_valid_bus = N_SRC'(1) << 1;
        in_data      = 8'h99;
        tick();
        in_valid_bus = '0;
        check("t3_drop",     drop,     1);
        check("t3_tx_valid", tx_valid, 1);
        check("t3_tx_data",  tx_data,  PREFIX);
        check_frame("t3", 1, d, 8'hE0);

        // 4: a different source inside the gap closes the frame, its byte lost
        d = '{8'h77};
        send_bytes(3, d);
        tick(); tick(); tick();
        in_valid_bus = N_SRC'(1) << 4;
        in_data      = 8'h88;
        tick();
        in_valid_bus = '0;
        check("t4_drop",     drop,     1);
        check("t4_tx_valid", tx_valid, 1);
        check_frame("t4", 3, d, 8'h77);

        // Multi-hot offer: lowest bit wins, byte kept, drop pulses
        in_valid_bus = 8'b0110_0000;
        in_data      = 8'h5A;
        tick();
        in_valid_bus = '0;
        check("mh_drop", drop, 1);
        tick();
        check("mh_drop_clear", drop, 0);
        d = '{8'h5A};
        check_frame("mh", 5, d, 8'h5A);

        // 5: stall mid-data for 10 cycles
        d = '{8'h10, 8'h20, 8'h30, 8'h40};
        send_bytes(5, d);
        cyc = 0;
        while (!(tx_valid && tx_data == 8'h30) && cyc < 200) begin
            tick();
            cyc++;
        end
        check("t5_found", 32'(cyc < 200), 32'd1);
        tx_ready = 1'b0;
        stable = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (tx_valid && tx_data == 8'h30) stable++;
        end
        check("t5_stable", stable, 10);
        tx_ready = 1'b1;
        check_frame("t5", 5, d, 8'hA0);

        // Reset mid-frame: everything returns to reset values at once
        d = '{8'h01, 8'h02};
        send_bytes(7, d);
        cyc = 0;
        while (!tx_valid && cyc < 100) begin
            tick();
            cyc++;
        end
        tick(); tick();
        check("rm_mid_frame", busy, 1);
        #2 n_rst = 1'b0;
        #1;
        check("rm_tx_valid", tx_valid, 0);
        check("rm_tx_data",  tx_data,  0);
        check("rm_busy",     busy,     0);
        check("rm_in_ready", in_ready, 1);
        #3 n_rst = 1'b1;
        tick();
        rx_q.delete();
        d = '{8'h11};
        send_bytes(6, d);
        check_frame("rm_fresh", 6, d, 8'h11);

`ifdef TX_TIMEOUT_EN
        // 6: transmitter stuck, frame aborted after TO_CYC stall cycles
        tx_ready = 1'b0;
        d = '{8'h33};
        send_bytes(2, d);
        cyc = 0;
        while (!tx_valid && cyc < 100) begin
            tick();
            cyc++;
        end
        cyc = 0;
        while (tx_valid && cyc < 100) begin
            tick();
            cyc++;
        end
        check("t6_stall_cycles", cyc, TO_CYC);
        check("t6_drop", drop, 1);
        check("t6_busy", busy, 0);
        tx_ready = 1'b1;
        tick();
        rx_q.delete();
        d = '{8'h44};
        send_bytes(4, d);
        check_frame("t6_fresh", 4, d, 8'h44);
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/reply_encoder.md
Name: reply_encoder

Overview:
- Transmit-side counterpart of the host command path: collects response bytes written by on-board sources and frames each burst as a packet.
- Frame on the byte stream: `PREFIX, SELF_ADDR, SRC, LEN, DATA[0..LEN-1], CRC.
- Sits between the source blocks (one-hot valid bus, shared data byte) and the UART transmitter (valid/ready byte stream).
- CRC is the 8-bit modulo-256 sum of the DATA bytes only, the same rule the host-command decoder checks.

Parameters:
N_SRC, `N_SRC, number of sources; width of in_valid_bus
PREFIX, `PREFIX, first byte of every frame
SELF_ADDR, `ADDR_AST, second byte of every frame (board address)
MAX_LEN, 64, max DATA bytes per frame (1..255); also buffer depth
GAP_CYC, 16, idle cycles after last accepted byte that close a frame (>=1)
TX_TIMEOUT_CYC, 50000000, stall limit for the optional feature

Ports:
clk  in  1  system clock
n_rst  in  1  asynchronous active-low reset
in_data  in  8  byte from a source
in_valid_bus  in  N_SRC  one-hot write strobe; bit i = byte from source i
in_ready  out  1  encoder can accept a byte this cycle
tx_data  out  8  framed byte to UART
tx_valid  out  1  tx_data valid
tx_ready  in  1  UART accepts tx_data
busy  out  1  state != IDLE
drop  out  1  one-cycle pulse: an offered byte was discarded or a frame was aborted

Behaviour:
- Reset (async, n_rst low) values: state IDLE, tx_valid 0, tx_data 0, drop 0, cnt 0, crc 0, src 0. in_ready evaluates to 1. Buffer contents are don't-care.
- in_ready = (state==IDLE) | (state==COLLECT & cnt<MAX_LEN). It is not a function of in_valid_bus.
- Byte offer: any bit of in_valid_bus set. Multi-hot offer: lowest set bit wins and the byte is accepted; drop pulses next cycle.
- IDLE: on an offer, store the byte at buf[0], latch src = index of the winning bit, cnt=1, crc=in_data, gap counter=0, then go to COLLECT.
- COLLECT, offer from the same src with cnt<MAX_LEN: store at buf[cnt], cnt+1, crc+=in_data, gap counter=0.
- COLLECT, offer from a different src: byte discarded, drop pulses, go to SEND_PREFIX the same cycle.
- COLLECT, no offer: gap counter +1. At GAP_CYC-1, go to SEND_PREFIX.
- COLLECT, cnt==MAX_LEN: go to SEND_PREFIX on the next cycle with no gap wait. Offers made while in_ready=0 are ignored; drop pulses for them.
- Send states: SEND_PREFIX, SEND_ADDR, SEND_SRC, SEND_LEN, SEND_DATA, SEND_CRC.
  - On entering each send state, tx_data is registered with that state's byte and tx_valid=1.
  - A byte transfers only on a cycle with tx_valid & tx_ready. tx_data stays stable while tx_valid=1 & tx_ready=0.
  - After each transfer, advance to the next state and present its byte on the following cycle (one bubble allowed between bytes).
  - SEND_SRC sends {zero-extended src}. SEND_LEN sends cnt.
  - SEND_DATA sends buf[0..cnt-1] in order, using read index rd. After the transfer of buf[cnt-1], go to SEND_CRC.
  - After the CRC transfer: tx_valid=0, cnt=0, crc=0, go to IDLE.
- All offers during send states are ignored with drop pulsed (in_ready=0).
- Latency: first frame byte presented no later than 2 cycles after COLLECT exit.
- Arithmetic: cnt and rd are 8-bit. crc wraps mod 256. LEN is never 0.
- A reset mid-frame returns everything to reset values immediately. A partial frame is never resumed.

Optional Feature:
- Macro TX_TIMEOUT_EN.
- Defined: a 32-bit counter clears on every tx transfer and in IDLE/COLLECT, and increments while tx_valid & !tx_ready. On reaching TX_TIMEOUT_CYC-1: tx_valid=0, buffer discarded, drop pulses, state goes to IDLE next cycle.
- Undefined: no counter; the encoder waits on tx_ready indefinitely.

Test Plan:
1. Source 2 writes 3 bytes 0x01,0x02,0x03 back-to-back, tx_ready=1 -> after GAP_CYC idle cycles, stream is `PREFIX, `ADDR_AST, 0x02, 0x03, 0x01, 0x02, 0x03, 0x06; busy returns 0.
2. Source 0 writes bytes 0xFF,0x02 -> CRC byte 0x01 (wrap); LEN 0x02.
3. Source 1 writes MAX_LEN bytes continuously -> frame starts with no gap wait; LEN=MAX_LEN; a 65th offer sees in_ready=0 and drop pulses.
4. Source 3 writes 1 byte, then source 4 writes 1 byte within the gap -> frame with SRC=3, LEN=1 is sent; source-4 byte dropped with drop pulse.
5. tx_ready held low for 10 cycles in the middle of SEND_DATA -> tx_data/tx_valid stable throughout; frame completes intact after release.
6. With TX_TIMEOUT_EN and TX_TIMEOUT_CYC=20, tx_ready stuck low -> after 20 stall cycles tx_valid=0, drop pulses, IDLE. Next offer starts a fresh frame. Also: n_rst pulsed mid-frame -> all outputs return to reset values at once.
